// File: rtl/chg_event_uart_tx.sv
// Change-event UART transmitter: queues {channel, value} events in a small
// FIFO and sends each one as a header byte plus a data byte, 8N1.
module chg_event_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       evt_valid,
    input  logic [1:0] evt_ch,
    input  logic [7:0] evt_data,
    input  logic       ovf_clr,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow,
    output logic [3:0] fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] DEPTH = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [9:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [3:0]    r_level;
    logic          r_ovf;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic          r_byte_sel;
    logic [9:0]    r_hold;
    logic          r_tx;
    logic          r_busy;

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_bit_end;
    logic [7:0]    w_byte;
    logic [2:0]    w_next_idx;

    // Full is judged on the start-of-cycle level, so a pop never frees a slot
    // for a write in the same cycle.
    assign w_full     = (r_level == DEPTH);
    assign w_push     = evt_valid && !w_full;
    assign w_pop      = (r_state == IDLE) && (r_level != 4'd0);
    assign w_bit_end  = (r_cnt == CNT_MAX);
    assign w_byte     = r_byte_sel ? r_hold[7:0]
                                   : {4'b1010, 2'b00, r_hold[9:8]};
    assign w_next_idx = r_bit_idx + 3'd1;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {evt_ch, evt_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= 4'd0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 4'd1;
                2'b01:   r_level <= r_level - 4'd1;
                default: r_level <= r_level;
            endcase
            if (evt_valid && w_full) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= 3'd0;
            r_byte_sel <= 1'b0;
            r_hold     <= 10'd0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_hold     <= r_mem[r_rd_ptr];
                        r_byte_sel <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= START;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_bit_idx <= 3'd0;
                        r_state   <= DATA;
                        r_tx      <= w_byte[0];
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= w_next_idx;
                            r_tx      <= w_byte[w_next_idx];
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (!r_byte_sel) begin
                            r_byte_sel <= 1'b1;
                            r_state    <= START;
                            r_tx       <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign fifo_full  = w_full;
    assign overflow   = r_ovf;
    assign fifo_level = r_level;

endmodule

// File: tb/tb_chg_event_uart_tx.sv
// Bench for chg_event_uart_tx: frame-level reference model checked every
// cycle, plus a vector table and hand-written corner sequences.
module tb_chg_event_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FLEN  = 20 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       evt_valid = 1'b0;
    logic [1:0] evt_ch = 2'd0;
    logic [7:0] evt_data = 8'd0;
    logic       ovf_clr = 1'b0;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic       overflow;
    logic [3:0] fifo_level;

    chg_event_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .evt_valid  (evt_valid),
        .evt_ch     (evt_ch),
        .evt_data   (evt_data),
        .ovf_clr    (ovf_clr),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // Reference model: event queue plus the frame currently on the wire.
    logic [9:0]  mq[$];
    bit          m_active = 0;
    int          m_off = 0;
    logic [19:0] m_bits = '1;
    bit          m_ovf = 0;

    function automatic logic [19:0] frame_bits(logic [9:0] e);
        logic [7:0] hdr;
        hdr = {4'b1010, 2'b00, e[9:8]};
        return {1'b1, e[7:0], 1'b0, 1'b1, hdr, 1'b0};
    endfunction

    function automatic void model_edge(bit v, logic [1:0] ch, logic [7:0] d, bit clr);
        int  sz;
        bit  pop;
        bit  full;
        sz   = mq.size();
        pop  = !m_active && sz > 0;
        full = (sz == DEPTH);
        if (v && full) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (m_active) begin
            m_off++;
            if (m_off == FLEN) m_active = 0;
        end
        if (pop) begin
            m_bits   = frame_bits(mq.pop_front());
            m_active = 1;
            m_off    = 0;
        end
        if (v && !full) mq.push_back({ch, d});
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_active = 0;
        m_off    = 0;
        m_ovf    = 0;
    endfunction

    function automatic void model_check();
        logic exp_tx;
        exp_tx = m_active ? m_bits[m_off / CPB] : 1'b1;
        chk("tx", tx, exp_tx);
        chk("busy", busy, m_active);
        chk("level", fifo_level, mq.size());
        chk("full", fifo_full, mq.size() == DEPTH);
        chk("overflow", overflow, m_ovf);
    endfunction

    task automatic step(input bit v, input logic [1:0] ch,
                        input logic [7:0] d, input bit clr);
        evt_valid = v;
        evt_ch    = ch;
        evt_data  = d;
        ovf_clr   = clr;
        @(posedge clk);
        model_edge(v, ch, d, clr);
        @(negedge clk);
        evt_valid = 1'b0;
        ovf_clr   = 1'b0;
        model_check();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_active || mq.size() > 0) && n < 3000) begin
            step(0, 2'd0, 8'd0, 0);
            n++;
        end
        chk("drain_done", (m_active || mq.size() > 0), 0);
        step(0, 2'd0, 8'd0, 0);
    endtask

    typedef struct {
        bit         v;
        logic [1:0] ch;
        logic [7:0] d;
        bit         clr;
        int         lvl;
        bit         full;
        bit         ovf;
        bit         bsy;
    } vec_t;

    vec_t tbl[9];
    int   se_exp[20];

    initial begin
        int peak;
        int sent;
        int n;

        tbl[0] = '{1, 2'd0, 8'h11, 0, 1, 0, 0, 0};
        tbl[1] = '{1, 2'd1, 8'h22, 0, 1, 0, 0, 1};
        tbl[2] = '{1, 2'd2, 8'h33, 0, 2, 0, 0, 1};
        tbl[3] = '{1, 2'd3, 8'h44, 0, 3, 0, 0, 1};
        tbl[4] = '{1, 2'd0, 8'h55, 0, 4, 1, 0, 1};
        tbl[5] = '{1, 2'd1, 8'h66, 0, 4, 1, 1, 1};
        tbl[6] = '{1, 2'd2, 8'h77, 1, 4, 1, 1, 1};
        tbl[7] = '{0, 2'd0, 8'h00, 1, 4, 1, 0, 1};
        tbl[8] = '{0, 2'd0, 8'h00, 0, 4, 1, 0, 1};

        // ch=2, data=0x5C: start, 0xA2 LSB first, stop, start, 0x5C, stop
        se_exp = '{0, 0,1,0,0,0,1,0,1, 1, 0, 0,0,1,1,1,0,1,0, 1};

        @(negedge clk);
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_full", fifo_full, 0);
        rst_n = 1'b1;
        step(0, 2'd0, 8'd0, 0);

        // Single event, bit-exact waveform
        step(1, 2'd2, 8'h5C, 0);
        chk("se_tx_at_E", tx, 1);
        chk("se_busy_at_E", busy, 0);
        for (int k = 0; k < FLEN; k++) begin
            step(0, 2'd0, 8'd0, 0);
            chk("se_tx", tx, se_exp[k / CPB]);
            chk("se_busy", busy, 1);
        end
        step(0, 2'd0, 8'd0, 0);
        chk("se_busy_end", busy, 0);
        chk("se_tx_end", tx, 1);

        // Burst of five consecutive events
        peak = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 2'(i % 4), 8'(8'h30 + i), 0);
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 2'd0, 8'd0, 0);
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
        end
        chk("burst_peak", peak, 4);
        chk("burst_ovf", overflow, 0);
        drain();

        // Overflow table
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].clr);
            chk("tbl_level", fifo_level, tbl[i].lvl);
            chk("tbl_full", fifo_full, tbl[i].full);
            chk("tbl_ovf", overflow, tbl[i].ovf);
            chk("tbl_busy", busy, tbl[i].bsy);
        end
        drain();

        // Pointer wrap-around with ten distinct events
        sent = 0;
        n = 0;
        while (sent < 10 && n < 5000) begin
            if (mq.size() < DEPTH) begin
                step(1, 2'(sent % 4), 8'(8'h10 + sent), 0);
                sent++;
            end else begin
                step(0, 2'd0, 8'd0, 0);
            end
            n++;
        end
        chk("wrap_sent", sent, 10);
        drain();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit v;
            v = (i < 1500) ? ($urandom_range(0, 99) < 3)
                           : ($urandom_range(0, 99) < 40);
            step(v, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                 $urandom_range(0, 19) == 0);
        end
        drain();

        // Reset in the middle of byte 1 with two events queued
        step(1, 2'd0, 8'hAA, 0);
        step(1, 2'd1, 8'hBB, 0);
        step(1, 2'd2, 8'hCC, 0);
        chk("mid_level", fifo_level, 2);
        n = 0;
        while (!(m_active && m_off == 11 * CPB) && n < 200) begin
            step(0, 2'd0, 8'd0, 0);
            n++;
        end
        chk("mid_reach", m_active && m_off == 11 * CPB, 1);
        chk("mid_tx_pre", tx, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_full", fifo_full, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) step(0, 2'd0, 8'd0, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_tx", tx, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/chg_event_uart_tx.md
Name: chg_event_uart_tx

Overview:
- Downstream consumer of the channel change detector.
- Each cycle the detector flags a channel update, this block captures the event: channel index plus new 8-bit value.
- Events are buffered in a small FIFO and serialized off-chip as two-byte 8N1 UART frames on a single output pin.
- This decouples bursty change events from the slow serial link and reports dropped events.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per UART bit. Minimum 2.
- FIFO_DEPTH, 4, event entries. Power of two, 2..8.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- evt_valid  in  1  change event strobe, one event per high cycle
- evt_ch  in  2  channel index of the event
- evt_data  in  8  new stored value for that channel
- ovf_clr  in  1  clears sticky overflow
- tx  out  1  UART serial output, idle high
- busy  out  1  a frame is being transmitted
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- overflow  out  1  sticky: an event was dropped
- fifo_level  out  4  current FIFO occupancy, 0..FIFO_DEPTH

Behaviour:
- Reset, asynchronous on rst_n low:
  - tx=1, busy=0, fifo_full=0, overflow=0, fifo_level=0.
  - FIFO pointers cleared; FSM goes to IDLE.
  - Reset mid-frame aborts the frame immediately (tx forced high) and discards all queued events.
- FIFO:
  - 10-bit entries {evt_ch, evt_data}.
  - Write occurs on a clock edge with evt_valid=1 and fifo_level<FIFO_DEPTH, using the level at the start of that cycle.
  - A pop in the same cycle does not make room for a write. Push and pop together when not full leaves the level unchanged.
  - evt_valid=1 while full: event dropped, overflow set.
  - overflow clears on ovf_clr=1. If a set and ovf_clr occur in the same cycle, set wins.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_full = (fifo_level==FIFO_DEPTH).
- Frame format:
  - Byte 0 header = {4'b1010, 2'b00, ch}.
  - Byte 1 = data.
  - Each byte: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Every bit is held exactly CLKS_PER_BIT cycles.
  - No idle gap between byte 0 stop and byte 1 start. One event = 20 bit-times.
- FSM states and transitions:
  - IDLE: tx=1, busy=0. If FIFO non-empty: pop head entry into the holding register, byte_sel=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA: tx=shift[bit_idx]. After CLKS_PER_BIT cycles, increment bit_idx. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then if byte_sel=0: byte_sel=1, go to START. Else go to IDLE.
  - busy=1 in START/DATA/STOP.
- Latency:
  - evt_valid sampled at edge E with FIFO empty and FSM in IDLE: entry written at E, popped at E+1.
  - tx falls and busy rises at E+1 (registered outputs).
  - Frame ends 20*CLKS_PER_BIT cycles later.
  - Back-to-back queued events: one IDLE cycle between frames.
- Data integrity: the holding register is loaded only on pop. New events never alter the frame in flight.
- Width: bit-period counter sized for CLKS_PER_BIT-1; bit_idx 3 bits; level counter 4 bits.

Test Plan:
- Reset values: assert rst_n=0 mid-simulation -> tx=1, busy=0, fifo_level=0, overflow=0 within the same cycle, without a clock edge.
- Single event (CLKS_PER_BIT=4): evt_ch=2, evt_data=8'h5C -> header 0xA2 serialized as bits 0,1,0,0,0,1,0,1 and data 0x5C as 0,0,1,1,1,0,1,0, each 4 cycles. Full frame 80 cycles, tx low at E+1, busy deasserts after final stop bit.
- Burst of 5 events on consecutive cycles with FIFO_DEPTH=4, first entry popped:
  - All 5 accepted (pop at E+1 frees space); fifo_level peaks at 4; overflow stays 0.
  - Frames emitted in order with one idle cycle between them.
- Overflow: hold FSM busy, issue 6 events -> 4 queued, the excess dropped, overflow=1, fifo_full=1. ovf_clr asserted in the same cycle as a further dropped event -> overflow stays 1. ovf_clr alone -> overflow=0.
- Wrap-around: push/pop 10 events with distinct data (ch=i%4, data=8'h10+i) -> received bytes match in order, pointers wrap correctly.
- Reset mid-frame: rst_n low during DATA of byte 1 with 2 events queued -> tx=1 immediately. After release, no further frames until a new evt_valid.
